ldlt_solve: RTL and testbench
=============================

LDLT_SOLVE -- requirements
Module: ldlt_solve

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: word width of all data, signed two's complement.
REQ-002 SHALL have parameter DIM, default 6: system order N, legal range 2..64.
REQ-003 SHALL have parameter FRACTION, default 16: number of fractional bits in fixed point (Q format).
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_start, input, 1 bit: start request; honoured only in IDLE.
REQ-007 SHALL have port i_valid, input, 1 bit: i_data carries a word.
REQ-008 SHALL have port i_data, input, DATA_LEN bits: factor or right-hand-side word.
REQ-009 SHALL have port o_ready, output, 1 bit: block accepts a word; a word transfers when i_valid && o_ready at a clock edge.
REQ-010 SHALL have port o_valid, output, 1 bit: o_data holds a solution word.
REQ-011 SHALL have port o_data, output, DATA_LEN bits: solution element x[i].
REQ-012 SHALL have port o_err, output, 1 bit: sticky flag, zero diagonal encountered.

Function
REQ-013 SHALL solve L*D*L^T*x = b, where L is unit lower-triangular and D is diagonal, all values in Q(FRACTION).
REQ-014 SHALL implement FSM states IDLE, LOAD_M, LOAD_B, FWD, DIAG, BWD, OUT; transitions:
- IDLE->LOAD_M on i_start.
- LOAD_M->LOAD_B after N(N+1)/2 transfers.
- LOAD_B->FWD after N transfers.
- FWD->DIAG->BWD->OUT.
- OUT->IDLE after the last output word.
REQ-015 SHALL accept factor words in LOAD_M packed column-major: for j=0..N-1 and i=j..N-1, the word is D[j] when i==j, else L[i][j].
REQ-016 SHALL accept b[0..N-1] in order during LOAD_B.
REQ-017 SHALL drive o_ready registered: high from the cycle after i_start is accepted until the edge where the final b word transfers; low in all other states.
REQ-018 SHALL ignore i_valid while o_ready is low.
REQ-019 SHALL ignore i_start outside IDLE.
REQ-020 FWD SHALL compute y[i] = b[i] - sum over k<i of L[i][k]*y[k], one multiply-accumulate per cycle, taking exactly N(N-1)/2 cycles.
REQ-021 DIAG SHALL compute z[i] = (y[i] << FRACTION) / D[i], one element per cycle, taking N cycles; quotient truncates toward zero.
REQ-022 BWD SHALL compute x[i] = z[i] - sum over k>i of L[k][i]*x[k], for i from N-1 down to 0, one multiply-accumulate per cycle, taking N(N-1)/2 cycles.
REQ-023 Each product SHALL be formed at full 2*DATA_LEN width, then arithmetic-shifted right by FRACTION.
REQ-024 Results SHALL be truncated to DATA_LEN bits (wrap), unless REQ-034 applies.
REQ-025 If D[i]==0, z[i] SHALL be 2^(DATA_LEN-1)-1 when y[i]>=0, else -2^(DATA_LEN-1); o_err SHALL be set and held until the next accepted i_start.
REQ-026 SHALL assert o_valid first at edge T+N*N+1, where T is the edge the last b word transfers.
REQ-027 OUT SHALL emit x[0]..x[N-1] on N consecutive cycles with o_valid high; o_valid and o_data SHALL be 0 otherwise.
REQ-028 There is no output backpressure.
REQ-029 SHALL clear o_err on an accepted i_start.
REQ-030 A new i_start SHALL be accepted in the cycle after OUT ends.

Reset
REQ-031 On rst_n low, SHALL immediately force IDLE and clear all counters.
REQ-032 On rst_n low, SHALL set o_ready=0, o_valid=0, o_data=0, o_err=0.
REQ-033 Reset SHALL abort any operation mid-flight; the stored matrix and vector contents are don't-care afterwards.

Configuration
REQ-034 When macro LDLT_SOLVE_SAT_EN is defined, every accumulate and every shifted product SHALL saturate to [-2^(DATA_LEN-1), 2^(DATA_LEN-1)-1], and saturation SHALL also set o_err. Without the macro, results wrap per REQ-024 and o_err reflects only REQ-025.

Verification
REQ-035 DIM=3, F=16: L=I, D all 0x20000, b all 0x10000 -> x = 0x8000, 0x8000, 0x8000; o_err=0.
REQ-036 DIM=3: D all 0x10000, L10=0x8000, L20=L21=0, b all 0x10000 -> x = 0xC000, 0x8000, 0x10000.
REQ-037 DIM=3: D1=0 with y1 positive -> z1=0x7FFFFFFF; o_err=1 until the next i_start.
REQ-038 i_valid toggled randomly during load; i_start pulsed during FWD -> identical x to REQ-036, start ignored, o_valid first at T+10.
REQ-039 rst_n low during BWD -> outputs 0 next cycle; a subsequent full run produces correct results.
REQ-040 LDLT_SOLVE_SAT_EN defined, b=0x7FFF0000, L10=0xFFFF0000 (-1.0) -> y1 clamps to 0x7FFFFFFF, o_err=1; without the macro it wraps and o_err=0.

Source files
------------

// File: rtl/ldlt_solve_if.sv
// Stream interface for ldlt_solve: start/load handshake in, solution words and error flag out.
interface ldlt_solve_if #(
    parameter int DATA_LEN = 32
);
    logic                i_start;
    logic                i_valid;
    logic [DATA_LEN-1:0] i_data;
    logic                o_ready;
    logic                o_valid;
    logic [DATA_LEN-1:0] o_data;
    logic                o_err;

    modport master (
        output i_start, i_valid, i_data,
        input  o_ready, o_valid, o_data, o_err
    );

    modport slave (
        input  i_start, i_valid, i_data,
        output o_ready, o_valid, o_data, o_err
    );
endinterface

// File: rtl/ldlt_solve.sv
// Fixed-point L*D*L^T x = b solver: streamed factors and rhs in, x[0..N-1] out.
// Define LDLT_SOLVE_SAT_EN to saturate products/accumulates (and flag them on o_err).
module ldlt_solve #(
    parameter int DATA_LEN = 32,
    parameter int DIM      = 6,
    parameter int FRACTION = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ldlt_solve_if.slave bus
);
    localparam int W  = DATA_LEN;
    localparam int W2 = 2 * DATA_LEN;
    localparam int IW = $clog2(DIM);
`ifdef LDLT_SOLVE_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif
    localparam logic [IW-1:0] Last   = IW'(DIM - 1);
    localparam logic [IW-1:0] LastM1 = IW'(DIM - 2);
    localparam logic signed [W2-1:0] WMax = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [W2-1:0] WMin = {{(W + 1){1'b1}}, {(W - 1){1'b0}}};

    typedef logic signed [W-1:0] word_t;
    typedef enum logic [2:0] {StIdle, StLoadM, StLoadB, StFwd, StDiag, StBwd, StOut} state_t;

    function automatic logic signed [W2-1:0] sext(input logic signed [W-1:0] a);
        return {{W{a[W-1]}}, a};
    endfunction

    // Returns {overflow, word}; overflow can only be raised in the saturating build.
    function automatic logic [W:0] fit(input logic signed [W2-1:0] val);
        if (SatEn && (val > WMax)) return {1'b1, WMax[W-1:0]};
        if (SatEn && (val < WMin)) return {1'b1, WMin[W-1:0]};
        return {1'b0, val[W-1:0]};
    endfunction

    state_t  r_state, w_state_d;
    logic [IW-1:0] r_i, r_k;
    logic    r_ready, r_valid, r_err;
    word_t   r_data;
    word_t   r_m [DIM][DIM];
    word_t   r_v [DIM];

    logic    w_xfer, w_den_zero, w_err_set;
    word_t   w_coef, w_z;
    logic [W:0] w_p, w_acc, w_q;
    logic signed [W2-1:0] w_prod, w_den, w_den_safe, w_quot;

    assign w_xfer      = bus.i_valid && r_ready;
    assign bus.o_ready = r_ready;
    assign bus.o_valid = r_valid;
    assign bus.o_data  = r_data;
    assign bus.o_err   = r_err;

    // Shared MAC/divide datapath; r_v holds b, then y, then z, then x in place.
    always_comb begin
        w_coef = (r_state == StBwd) ? r_m[r_k][r_i] : r_m[r_i][r_k];
        w_prod = sext(w_coef) * sext(r_v[r_k]);
        w_p    = fit(w_prod >>> FRACTION);
        w_acc  = fit(sext(r_v[r_i]) - sext(w_p[W-1:0]));
        w_den  = sext(r_m[r_i][r_i]);
        w_den_zero = (w_den == '0);
        if (w_den_zero) w_den_safe = 1;
        else            w_den_safe = w_den;
        w_quot = (sext(r_v[r_i]) <<< FRACTION) / w_den_safe;
        w_q    = fit(w_quot);
        if (w_den_zero) w_z = r_v[r_i][W-1] ? WMin[W-1:0] : WMax[W-1:0];
        else            w_z = w_q[W-1:0];
        w_err_set = 1'b0;
        if ((r_state == StFwd) || (r_state == StBwd)) w_err_set = w_p[W] | w_acc[W];
        if (r_state == StDiag)                        w_err_set = w_den_zero | w_q[W];
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (bus.i_start) w_state_d = StLoadM;
            StLoadM: if (w_xfer && (r_i == Last) && (r_k == Last)) w_state_d = StLoadB;
            StLoadB: if (w_xfer && (r_i == Last)) w_state_d = StFwd;
            StFwd:   if ((r_i == Last) && (r_k == LastM1)) w_state_d = StDiag;
            StDiag:  if (r_i == Last) w_state_d = StBwd;
            StBwd:   if ((r_i == '0) && (r_k == IW'(1))) w_state_d = StOut;
            StOut:   if (r_i == Last) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_i     <= '0;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ready <= (w_state_d == StLoadM) || (w_state_d == StLoadB);
            r_valid <= (r_state == StOut);
            r_data  <= (r_state == StOut) ? r_v[r_i] : '0;
            if ((r_state == StIdle) && bus.i_start) r_err <= 1'b0;
            else if (w_err_set)                    r_err <= 1'b1;
            case (r_state)
                StIdle: begin
                    r_i <= '0;
                    r_k <= '0;
                end
                StLoadM: if (w_xfer) begin
                    // r_k walks columns, r_i walks rows j..N-1 within a column.
                    if (r_i == Last) begin
                        r_k <= (r_k == Last) ? '0 : r_k + 1'b1;
                        r_i <= (r_k == Last) ? '0 : r_k + 1'b1;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                StLoadB: if (w_xfer) begin
                    r_i <= (r_i == Last) ? IW'(1) : r_i + 1'b1;
                    r_k <= '0;
                end
                StFwd: begin
                    if (w_state_d == StDiag) begin
                        r_i <= '0;
                        r_k <= '0;
                    end else if (r_k == r_i - 1'b1) begin
                        r_i <= r_i + 1'b1;
                        r_k <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                StDiag: begin
                    r_i <= (r_i == Last) ? LastM1 : r_i + 1'b1;
                    r_k <= Last;
                end
                StBwd: begin
                    if (w_state_d == StOut) begin
                        r_i <= '0;
                        r_k <= '0;
                    end else if (r_k == r_i + 1'b1) begin
                        r_i <= r_i - 1'b1;
                        r_k <= Last;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                StOut: r_i <= (r_i == Last) ? '0 : r_i + 1'b1;
                default: begin
                    r_i <= '0;
                    r_k <= '0;
                end
            endcase
        end
    end

    // Operand storage is not reset; its contents are meaningless after an abort.
    always_ff @(posedge clk) begin
        case (r_state)
            StLoadM: if (w_xfer) r_m[r_i][r_k] <= bus.i_data;
            StLoadB: if (w_xfer) r_v[r_i] <= bus.i_data;
            StFwd, StBwd: r_v[r_i] <= w_acc[W-1:0];
            StDiag:  r_v[r_i] <= w_z;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ldlt_solve.sv
// Self-checking bench for ldlt_solve (N=3, Q16): directed table plus randomized model runs.
module tb_ldlt_solve;
    localparam int N = 3;
    localparam int W = 32;
    localparam int F = 16;
    localparam longint LMax = 64'sd2147483647;
    localparam longint LMin = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ldlt_solve_if #(.DATA_LEN(W)) bus ();
    ldlt_solve #(.DATA_LEN(W), .DIM(N), .FRACTION(F)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int l10, l20, l21;
        int d0, d1, d2;
        int b0, b1, b2;
        int x0, x1, x2;
        bit err;
    } vec_t;

    vec_t tbl [4];
    int   s_l [N][N];
    int   s_d [N];
    int   s_b [N];
    int   e_x [N];
    bit   e_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint red(input longint v, output bit o);
        o = 1'b0;
`ifdef LDLT_SOLVE_SAT_EN
        if (v > LMax) begin o = 1'b1; return LMax; end
        if (v < LMin) begin o = 1'b1; return LMin; end
        return v;
`else
        return longint'(int'(v));
`endif
    endfunction

    // Reference: straight forward/diagonal/backward substitution in 64-bit arithmetic.
    task automatic model();
        longint v [N];
        longint p;
        bit o;
        bit err;
        err = 1'b0;
        for (int i = 0; i < N; i++) v[i] = s_b[i];
        for (int i = 1; i < N; i++)
            for (int k = 0; k < i; k++) begin
                p    = red((longint'(s_l[i][k]) * v[k]) >>> F, o); err |= o;
                v[i] = red(v[i] - p, o);                          err |= o;
            end
        for (int i = 0; i < N; i++) begin
            if (s_d[i] == 0) begin
                v[i] = (v[i] >= 0) ? LMax : LMin;
                err  = 1'b1;
            end else begin
                v[i] = red((v[i] <<< F) / longint'(s_d[i]), o); err |= o;
            end
        end
        for (int i = N - 2; i >= 0; i--)
            for (int k = N - 1; k > i; k--) begin
                p    = red((longint'(s_l[k][i]) * v[k]) >>> F, o); err |= o;
                v[i] = red(v[i] - p, o);                          err |= o;
            end
        for (int i = 0; i < N; i++) e_x[i] = int'(v[i]);
        e_err = err;
    endtask

    task automatic set_vec(input int idx);
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) s_l[i][j] = 0;
        s_l[1][0] = tbl[idx].l10; s_l[2][0] = tbl[idx].l20; s_l[2][1] = tbl[idx].l21;
        s_d[0] = tbl[idx].d0; s_d[1] = tbl[idx].d1; s_d[2] = tbl[idx].d2;
        s_b[0] = tbl[idx].b0; s_b[1] = tbl[idx].b1; s_b[2] = tbl[idx].b2;
        e_x[0] = tbl[idx].x0; e_x[1] = tbl[idx].x1; e_x[2] = tbl[idx].x2;
        e_err  = tbl[idx].err;
    endtask

    task automatic load_case(input bit noisy, output int t_last, output bit ok);
        int words [$];
        ok = 1'b1;
        t_last = cyc;
        for (int j = 0; j < N; j++)
            for (int i = j; i < N; i++) words.push_back((i == j) ? s_d[j] : s_l[i][j]);
        for (int i = 0; i < N; i++) words.push_back(s_b[i]);
        // Junk word offered with the start: o_ready is still low, so it must be ignored.
        bus.i_start = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        check("ready_after_start", 32'(bus.o_ready), 32'd1);
        check("err_clear_on_start", 32'(bus.o_err), 32'd0);
        foreach (words[w]) begin
            int guard;
            bit done;
            guard = 0;
            done  = 1'b0;
            while (!done && guard < 64) begin
                bus.i_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.i_data  = bus.i_valid ? words[w] : $urandom;
                done = bus.i_valid && bus.o_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!done) begin
                check("load_timeout", 32'd0, 32'd1);
                bus.i_valid = 1'b0;
                ok = 1'b0;
                return;
            end
        end
        bus.i_valid = 1'b0;
        t_last = cyc;
        check("ready_low_after_load", 32'(bus.o_ready), 32'd0);
    endtask

    task automatic finish_case(input bit noisy, input bit pulse, input int t_last);
        int lat;
        lat = 0;
        while (!bus.o_valid && lat < 200) begin
            bus.i_start = pulse && (lat == 1);
            bus.i_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.i_data  = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        check("first_valid_edge", 32'(cyc - t_last), 32'(N * N + 1));
        for (int k = 0; k < N; k++) begin
            check($sformatf("valid_x%0d", k), 32'(bus.o_valid), 32'd1);
            check($sformatf("data_x%0d", k), bus.o_data, e_x[k]);
            @(posedge clk); #1;
        end
        check("valid_low_after_out", 32'(bus.o_valid), 32'd0);
        check("data_zero_after_out", bus.o_data, 32'd0);
        check("err_after_out", 32'(bus.o_err), 32'(e_err));
    endtask

    initial begin
        int  t;
        bit  ok;
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;

        tbl[0] = '{0, 0, 0, 'h20000, 'h20000, 'h20000, 'h10000, 'h10000, 'h10000,
                   'h8000, 'h8000, 'h8000, 1'b0};
        tbl[1] = '{'h8000, 0, 0, 'h10000, 'h10000, 'h10000, 'h10000, 'h10000, 'h10000,
                   'hC000, 'h8000, 'h10000, 1'b0};
        tbl[2] = '{0, 0, 0, 'h10000, 0, 'h10000, 'h10000, 'h10000, 'h10000,
                   'h10000, 'h7FFFFFFF, 'h10000, 1'b1};
`ifdef LDLT_SOLVE_SAT_EN
        tbl[3] = '{int'(32'hFFFF0000), 0, 0, 'h10000, 'h10000, 'h10000,
                   'h7FFF0000, 'h7FFF0000, 'h7FFF0000,
                   'h7FFFFFFF, 'h7FFFFFFF, 'h7FFF0000, 1'b1};
`else
        tbl[3] = '{int'(32'hFFFF0000), 0, 0, 'h10000, 'h10000, 'h10000,
                   'h7FFF0000, 'h7FFF0000, 'h7FFF0000,
                   'h7FFD0000, int'(32'hFFFE0000), 'h7FFF0000, 1'b0};
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.o_ready), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_data", bus.o_data, 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass 0 clean; pass 1 with random i_valid gaps and an i_start pulse during FWD.
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < 4; v++) begin
                set_vec(v);
                load_case(pass[0], t, ok);
                if (ok) finish_case(pass[0], pass[0], t);
                repeat (3) @(posedge clk);
                #1;
                check("err_sticky_idle", 32'(bus.o_err), 32'(e_err));
            end
        end

        // Abort during BWD after a zero pivot has set o_err.
        set_vec(2);
        load_case(1'b0, t, ok);
        while (cyc < t + 7) begin @(posedge clk); #1; end
        check("err_before_reset", 32'(bus.o_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(bus.o_ready), 32'd0);
        check("abort_valid", 32'(bus.o_valid), 32'd0);
        check("abort_data", bus.o_data, 32'd0);
        check("abort_err", 32'(bus.o_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        set_vec(1);
        load_case(1'b0, t, ok);
        if (ok) finish_case(1'b0, 1'b0, t);

        // Abort in the middle of the output burst.
        load_case(1'b0, t, ok);
        while (!bus.o_valid && cyc < t + 50) begin @(posedge clk); #1; end
        check("out_x0_before_abort", bus.o_data, e_x[0]);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.o_valid), 32'd0);
        check("abort_out_data", bus.o_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        set_vec(0);
        load_case(1'b0, t, ok);
        if (ok) finish_case(1'b0, 1'b0, t);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++)
                    s_l[i][j] = (j < i) ? int'($urandom_range(0, 'h1FFFF)) - 'h10000 : 0;
                s_d[i] = int'($urandom_range('h8000, 'h40000));
                if ($urandom_range(0, 1) == 1) s_d[i] = -s_d[i];
                if ($urandom_range(0, 7) == 0) s_d[i] = 0;
                s_b[i] = int'($urandom_range(0, 'hFFFFF)) - 'h80000;
            end
            model();
            load_case(1'($urandom_range(0, 1)), t, ok);
            if (ok) finish_case(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
